// File: rtl/symbol_serializer_pkg.sv
// Shared definitions for the symbol serializer: FSM state encoding and
// counter sizing helper.
package symbol_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/symbol_serializer_if.sv
// Word-in / symbol-out handshake bundle for the symbol serializer.
interface symbol_serializer_if #(parameter int N = 2);

    logic         in_valid;
    logic         in_ready;
    logic [1:N]   in_data;
    logic         out_valid;
    logic         out_bit;
    logic         out_last;
    logic         busy;

    modport master (
        output in_valid, in_data,
        input  in_ready, out_valid, out_bit, out_last, busy
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, out_valid, out_bit, out_last, busy
    );

endinterface

// File: rtl/symbol_serializer.sv
// Parallel-to-serial transmitter: captures an N-bit word and emits it one
// bit per cycle, index 1 first, with a frame-last marker on bit N.
//
// state | meaning
// IDLE  | no frame in flight, ready for a word
// SHIFT | presenting bit (cnt+1) of the captured word
module symbol_serializer
    import symbol_serializer_pkg::*;
#(
    parameter int N = 2
) (
    input logic                clock,
    input logic                reset_n,
    symbol_serializer_if.slave bus
);

    localparam int CW = cnt_width(N);

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [1:N]      word, word_nxt;
    logic            last;
    logic            accept;
    logic            sym;

    assign last         = (state == SHIFT) && (cnt == CW'(N - 1));
    // Ready on the final bit too, so frames can run back to back.
    assign bus.in_ready = (state == IDLE) || last;
    assign accept       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            word  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            word  <= word_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        word_nxt  = word;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SHIFT;
                    cnt_nxt   = '0;
                    word_nxt  = bus.in_data;
                end
            end
            SHIFT: begin
                if (last) begin
                    if (accept) begin
                        cnt_nxt  = '0;
                        word_nxt = bus.in_data;
                    end else begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Symbol select is a counter decode; held at 0 outside a frame.
    always_comb begin
        sym = 1'b0;
        for (int i = 0; i < N; i++) begin
            if ((state == SHIFT) && (cnt == CW'(i))) sym = word[i + 1];
        end
    end

    assign bus.out_valid = (state == SHIFT);
    assign bus.out_bit   = sym;
    assign bus.out_last  = last;
    assign bus.busy      = (state == SHIFT);

endmodule

// File: tb/tb_symbol_serializer.sv
// Randomized scoreboard bench running serializers of width 1, 2 and 4 side
// by side against a queue-of-symbols reference model, with async resets.
module tb_symbol_serializer;

    logic clock;
    logic reset_n;
    int   total;
    int   bad;
    int   dens;
    event finish_ev;

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_bit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        localparam int NN = (g == 0) ? 1 : (g == 1) ? 2 : 4;

        symbol_serializer_if #(.N(NN)) bus ();

        symbol_serializer #(.N(NN)) dut (
            .clock   (clock),
            .reset_n (reset_n),
            .bus     (bus.slave)
        );

        exp_t sb[$];
        int   frames;
        logic will_acc;

        // Producer: holds a word stable until it is taken.
        initial begin
            bus.in_valid = 1'b0;
            bus.in_data  = '0;
            frames       = 0;
            forever begin
                @(negedge clock);
                will_acc = bus.in_valid && bus.in_ready;
                @(posedge clock);
                #1;
                if (!bus.in_valid || will_acc) begin
                    bus.in_valid = ($urandom_range(99) < dens);
                    bus.in_data  = NN'($urandom);
                end
            end
        end

        // Reset drops everything in flight; outputs must clear before any edge.
        always @(negedge reset_n) begin
            sb.delete();
            #1;
            check_bit($sformatf("N%0d async out_valid", NN), bus.out_valid, 1'b0);
            check_bit($sformatf("N%0d async out_bit", NN), bus.out_bit, 1'b0);
            check_bit($sformatf("N%0d async out_last", NN), bus.out_last, 1'b0);
            check_bit($sformatf("N%0d async in_ready", NN), bus.in_ready, 1'b1);
        end

        always @(negedge clock) begin
            exp_t e;
            logic mr;
            if (!reset_n) begin
                check_bit($sformatf("N%0d rst out_valid", NN), bus.out_valid, 1'b0);
                check_bit($sformatf("N%0d rst in_ready", NN), bus.in_ready, 1'b1);
            end else begin
                // Ready when at most the current symbol remains outstanding.
                mr = (sb.size() <= 1);
                check_bit($sformatf("N%0d in_ready", NN), bus.in_ready, mr);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check_bit($sformatf("N%0d out_valid", NN), bus.out_valid, 1'b1);
                    check_bit($sformatf("N%0d busy", NN), bus.busy, 1'b1);
                    check_bit($sformatf("N%0d out_bit", NN), bus.out_bit, e.b);
                    check_bit($sformatf("N%0d out_last", NN), bus.out_last, e.last);
                end else begin
                    check_bit($sformatf("N%0d idle out_valid", NN), bus.out_valid, 1'b0);
                    check_bit($sformatf("N%0d idle busy", NN), bus.busy, 1'b0);
                    check_bit($sformatf("N%0d idle out_bit", NN), bus.out_bit, 1'b0);
                    check_bit($sformatf("N%0d idle out_last", NN), bus.out_last, 1'b0);
                end
                if (bus.in_valid && mr) begin
                    for (int i = 1; i <= NN; i++) begin
                        e.b    = bus.in_data[i];
                        e.last = (i == NN);
                        sb.push_back(e);
                    end
                    frames++;
                end
            end
        end

        initial begin
            @(finish_ev);
            check_int($sformatf("N%0d drained", NN), sb.size(), 0);
            check_int($sformatf("N%0d frames seen", NN), (frames > 20) ? 1 : 0, 1);
        end
    end

    initial begin
        int dens_tab[4];
        dens_tab = '{100, 60, 25, 90};
        total   = 0;
        bad     = 0;
        dens    = 0;
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #3 reset_n = 1'b1;
        for (int p = 0; p < 4; p++) begin
            dens = dens_tab[p];
            repeat (150) @(posedge clock);
            #3 reset_n = 1'b0;
            repeat (2) @(posedge clock);
            #3 reset_n = 1'b1;
            repeat (150) @(posedge clock);
        end
        dens = 0;
        repeat (12) @(posedge clock);
        ->finish_ev;
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
